// File: rtl/aud_recorder.sv
// I2S left-channel recorder: captures 16-bit left samples from the ADC serial stream and
// presents each one as a single-cycle SRAM write strobe at an incrementing word address.
module aud_recorder #(
  parameter logic [19:0] ADDR_MAX = 20'hFFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lrc,
  input  logic        i_data,
  input  logic        i_start,
  input  logic        i_pause,
  input  logic        i_stop,
  output logic [19:0] o_address,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_full
);

  typedef enum logic [1:0] {StIdle, StWait, StCapture, StPause} state_e;

  state_e      state_q, state_d;
  logic        lrc_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pause_q, pause_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        full_q, full_d;
  logic        lrc_fall;

  assign lrc_fall = !i_lrc && lrc_d;

  // State register and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      lrc_d   <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
      pause_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lrc_d   <= i_lrc;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      pause_q <= pause_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      full_q  <= full_d;
    end
  end

  // Next-state logic; control priority is stop > pause > start.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    pause_d = pause_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    full_d  = full_q;
    unique case (state_q)
      StIdle: begin
        if (!i_stop && !i_pause && i_start) begin
          state_d = StWait;
          addr_d  = '0;
          full_d  = 1'b0;
        end
      end
      StWait: begin
        if (i_stop) begin
          state_d = StIdle;
        end else if (i_pause) begin
          state_d = StPause;
        end else if (lrc_fall) begin
          // The falling LRC edge is the I2S delay bit; data starts on the next edge.
          state_d = StCapture;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      StCapture: begin
        if (valid_q) begin
          // Write cycle: the word is committed even if stop arrives now.
          pause_d = 1'b0;
          if (addr_q == ADDR_MAX) begin
            full_d  = 1'b1;
            state_d = StIdle;
          end else begin
            addr_d = addr_q + 20'd1;
            if (i_stop) begin
              state_d = StIdle;
            end else if (pause_q || i_pause) begin
              state_d = StPause;
            end else begin
              state_d = StWait;
            end
          end
        end else if (i_stop) begin
          state_d = StIdle;
          pause_d = 1'b0;
        end else begin
          if (i_pause) begin
            pause_d = 1'b1;
          end
          if (lrc_fall) begin
            // Frame restarted early: drop the partial word, this edge is the new delay bit.
            cnt_d   = '0;
            shift_d = '0;
          end else begin
            shift_d = {shift_q[14:0], i_data};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              data_d  = {shift_q[14:0], i_data};
              valid_d = 1'b1;
            end
          end
        end
      end
      StPause: begin
        if (i_stop) begin
          state_d = StIdle;
        end else if (!i_pause && i_start) begin
          state_d = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_address = addr_q;
  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_full    = full_q;
  assign o_busy    = (state_q == StWait) || (state_q == StCapture);

endmodule

// File: tb/tb_aud_recorder.sv
// Bench for aud_recorder: a default-depth instance and a 4-word instance share the serial
// inputs; expected writes are queued as frames are driven and popped on each o_valid.
module tb_aud_recorder;

  typedef struct packed {
    logic [19:0] a;
    logic [15:0] d;
  } wr_t;

  logic clk;
  logic rst_n;
  logic lrc, din, start, pause, stop;
  logic sel_small;
  logic start_m, start_s;

  logic [19:0] addr_m, addr_s;
  logic [15:0] data_m, data_s;
  logic        valid_m, valid_s, busy_m, busy_s, full_m, full_s;

  int total;
  int bad;
  int n_wr_s;
  wr_t sb_m[$];
  wr_t sb_s[$];
  wr_t mon_m, mon_s;

  assign start_m = start & !sel_small;
  assign start_s = start & sel_small;

  aud_recorder dut_m (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(din), .i_start(start_m),
    .i_pause(pause), .i_stop(stop), .o_address(addr_m), .o_data(data_m),
    .o_valid(valid_m), .o_busy(busy_m), .o_full(full_m)
  );

  aud_recorder #(.ADDR_MAX(20'd3)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(din), .i_start(start_s),
    .i_pause(pause), .i_stop(stop), .o_address(addr_s), .o_data(data_s),
    .o_valid(valid_s), .o_busy(busy_s), .o_full(full_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard for the default instance.
  always @(negedge clk) begin
    if (rst_n && valid_m) begin
      total++;
      if (sb_m.size() == 0) begin
        bad++;
        $display("FAIL main_unexpected_write: got addr=%h data=%h want no write", addr_m, data_m);
      end else begin
        mon_m = sb_m.pop_front();
        if (addr_m !== mon_m.a || data_m !== mon_m.d) begin
          bad++;
          $display("FAIL main_write: got addr=%h data=%h want addr=%h data=%h",
                   addr_m, data_m, mon_m.a, mon_m.d);
        end
      end
    end
  end

  // Scoreboard for the small instance.
  always @(negedge clk) begin
    if (rst_n && valid_s) begin
      n_wr_s++;
      total++;
      if (sb_s.size() == 0) begin
        bad++;
        $display("FAIL small_unexpected_write: got addr=%h data=%h want no write", addr_s, data_s);
      end else begin
        mon_s = sb_s.pop_front();
        if (addr_s !== mon_s.a || data_s !== mon_s.d) begin
          bad++;
          $display("FAIL small_write: got addr=%h data=%h want addr=%h data=%h",
                   addr_s, data_s, mon_s.a, mon_s.d);
        end
      end
    end
  end

  task automatic tick(input logic l, input logic d, input logic st, input logic pa,
                      input logic sp);
    @(negedge clk);
    lrc   = l;
    din   = d;
    start = st;
    pause = pa;
    stop  = sp;
  endtask

  // One 32-BCLK frame; left word bits sit on cycles 1..16, optional control pulse at ev_k.
  task automatic frame(input logic [15:0] w, input int ev_k, input logic st, input logic pa,
                       input logic sp, input bit wr, input logic [19:0] wa);
    wr_t  e;
    logic d;
    if (wr) begin
      e.a = wa;
      e.d = w;
      if (sel_small) sb_s.push_back(e);
      else sb_m.push_back(e);
    end
    for (int k = 0; k < 32; k++) begin
      if (k >= 1 && k <= 16) d = w[16-k];
      else d = 1'($urandom_range(0, 1));
      if (k == ev_k) tick(k >= 16, d, st, pa, sp);
      else tick(k >= 16, d, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    lrc = 1'b1; din = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    sel_small = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({addr_m, data_m, valid_m, busy_m, full_m} !== 39'd0) begin
      bad++;
      $display("FAIL reset_outputs: got addr=%h data=%h v=%b b=%b f=%b want all 0",
               addr_m, data_m, valid_m, busy_m, full_m);
    end
    rst_n = 1'b1;
    // Frames with no start must not capture.
    frame(16'h1234, -1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0);
    total++;
    if (busy_m !== 1'b0 || addr_m !== 20'd0) begin
      bad++;
      $display("FAIL no_start_idle: got busy=%b addr=%h want busy=0 addr=0", busy_m, addr_m);
    end
  endtask

  task automatic test_capture;
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (busy_m !== 1'b1 || addr_m !== 20'd0) begin
      bad++;
      $display("FAIL start_wait: got busy=%b addr=%h want busy=1 addr=0", busy_m, addr_m);
    end
    for (int i = 0; i < 3; i++) frame(16'hA5C3, -1, 1'b0, 1'b0, 1'b0, 1'b1, 20'(i));
    total++;
    if (addr_m !== 20'd3 || data_m !== 16'hA5C3) begin
      bad++;
      $display("FAIL capture_addr: got addr=%h data=%h want addr=3 data=a5c3", addr_m, data_m);
    end
  endtask

  task automatic test_pause;
    frame(16'h5A3C, 8, 1'b0, 1'b1, 1'b0, 1'b1, 20'd3);
    total++;
    if (busy_m !== 1'b0 || addr_m !== 20'd4) begin
      bad++;
      $display("FAIL pause_state: got busy=%b addr=%h want busy=0 addr=4", busy_m, addr_m);
    end
    frame(16'hFFFF, -1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(16'h8001, -1, 1'b0, 1'b0, 1'b0, 1'b1, 20'd4);
    total++;
    if (addr_m !== 20'd5) begin
      bad++;
      $display("FAIL resume_addr: got %h want %h", addr_m, 20'd5);
    end
  endtask

  task automatic test_stop;
    frame(16'h7E81, 11, 1'b0, 1'b0, 1'b1, 1'b0, 20'd0);
    total++;
    if (busy_m !== 1'b0 || addr_m !== 20'd5 || data_m !== 16'h8001) begin
      bad++;
      $display("FAIL stop_partial: got busy=%b addr=%h data=%h want busy=0 addr=5 data=8001",
               busy_m, addr_m, data_m);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (addr_m !== 20'd0 || busy_m !== 1'b1) begin
      bad++;
      $display("FAIL restart_addr: got addr=%h busy=%b want addr=0 busy=1", addr_m, busy_m);
    end
  endtask

  task automatic test_coincide;
    logic [15:0] w;
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (busy_m !== 1'b0) begin
      bad++;
      $display("FAIL all_three_idle: got busy=%b want %b", busy_m, 1'b0);
    end
    frame(16'h0F0F, -1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // Partial word: LRC rises after bit 7 and falls again on the edge of bit 8.
    w = 16'hFFFF;
    for (int k = 0; k < 8; k++) tick(1'b0, (k >= 1) ? w[16-k] : 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, w[8], 1'b0, 1'b0, 1'b0);
    frame(16'h3C5A, -1, 1'b0, 1'b0, 1'b0, 1'b1, 20'd0);
    total++;
    if (addr_m !== 20'd1 || data_m !== 16'h3C5A) begin
      bad++;
      $display("FAIL early_fall: got addr=%h data=%h want addr=1 data=3c5a", addr_m, data_m);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_full;
    sel_small = 1'b1;
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      frame(16'h1111 * 16'(i + 1), -1, 1'b0, 1'b0, 1'b0, i < 4, 20'(i));
    end
    total++;
    if (full_s !== 1'b1 || busy_s !== 1'b0 || addr_s !== 20'd3) begin
      bad++;
      $display("FAIL full_state: got full=%b busy=%b addr=%h want full=1 busy=0 addr=3",
               full_s, busy_s, addr_s);
    end
    total++;
    if (n_wr_s !== 4) begin
      bad++;
      $display("FAIL full_count: got %0d writes want 4", n_wr_s);
    end
    total++;
    if (full_m !== 1'b0 || busy_m !== 1'b0) begin
      bad++;
      $display("FAIL main_untouched: got full=%b busy=%b want 0 0", full_m, busy_m);
    end
    sel_small = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [15:0] w;
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(16'hBEEF, -1, 1'b0, 1'b0, 1'b0, 1'b1, 20'd0);
    w = 16'hFFFF;
    for (int k = 0; k < 13; k++) tick(1'b0, (k >= 1) ? w[16-k] : 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({addr_m, data_m, valid_m, busy_m, full_m} !== 39'd0) begin
      bad++;
      $display("FAIL reset_mid: got addr=%h data=%h v=%b b=%b f=%b want all 0",
               addr_m, data_m, valid_m, busy_m, full_m);
    end
    total++;
    if (full_s !== 1'b0 || addr_s !== 20'd0) begin
      bad++;
      $display("FAIL reset_small: got full=%b addr=%h want 0 0", full_s, addr_s);
    end
    @(negedge clk);
    lrc = 1'b1;
    rst_n = 1'b1;
    frame(16'h1357, -1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0);
    total++;
    if (busy_m !== 1'b0 || addr_m !== 20'd0) begin
      bad++;
      $display("FAIL post_reset_idle: got busy=%b addr=%h want 0 0", busy_m, addr_m);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(16'hC0DE, -1, 1'b0, 1'b0, 1'b0, 1'b1, 20'd0);
    total++;
    if (addr_m !== 20'd1) begin
      bad++;
      $display("FAIL post_reset_capture: got addr=%h want %h", addr_m, 20'd1);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    n_wr_s = 0;
    test_reset();
    test_capture();
    test_pause();
    test_stop();
    test_coincide();
    test_full();
    test_reset_mid();
    repeat (2) @(negedge clk);
    total++;
    if (sb_m.size() != 0 || sb_s.size() != 0) begin
      bad++;
      $display("FAIL missing_writes: got %0d/%0d pending want 0/0", sb_m.size(), sb_s.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
